// File: rtl/rv_sys_pkg.sv
// Shared types and helpers for the RV system memory / timer slave.
package rv_sys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REG_RAM   = 2'd0,
        REG_TIMER = 2'd1,
        REG_NONE  = 2'd2
    } region_e;

    // Byte offsets inside the 16-byte timer block
    localparam logic [3:0] MTIME    = 4'h0;
    localparam logic [3:0] MTIMECMP = 4'h4;
    localparam logic [3:0] CTRL     = 4'h8;

    // Classify a byte address; the timer block is assumed 16-byte aligned
    // and only its first three words are mapped.
    function automatic region_e decode_region(input logic [31:0] a,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] timer_base);
        region_e r;
        if ({a[31:2], 2'b00} < ram_bytes) begin
            r = REG_RAM;
        end else if ((a[31:4] == timer_base[31:4]) && (a[3:2] != 2'b11)) begin
            r = REG_TIMER;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

    // Replace only the enabled byte lanes of old_word with new_word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = lane_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_timer.sv
// Memory-mapped timer: free-running mtime, compare register, enable and
// a registered level interrupt.
module rv_timer
    import rv_sys_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  wr_off,
    input  logic [3:0]  be,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_off,
    output logic [31:0] rd_data,
    output logic        intr
);

    logic [31:0] mtime_r;
    logic [31:0] mtimecmp_r;
    logic        enable_r;

    // Free-running time base, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_r <= 32'd0;
        end else begin
            mtime_r <= mtime_r + 32'd1;
        end
    end

    // Software-writable compare and control registers; mtime writes are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            mtimecmp_r <= 32'hFFFF_FFFF;
            enable_r   <= 1'b0;
        end else if (we && (wr_off == MTIMECMP)) begin
            mtimecmp_r <= merge_bytes(mtimecmp_r, wr_data, be);
        end else if (we && (wr_off == CTRL) && be[0]) begin
            enable_r <= wr_data[0];
        end else begin
            mtimecmp_r <= mtimecmp_r;
            enable_r   <= enable_r;
        end
    end

    // Interrupt level, registered from the current register values
    always_ff @(posedge clk) begin
        if (reset) begin
            intr <= 1'b0;
        end else begin
            intr <= enable_r && (mtime_r >= mtimecmp_r);
        end
    end

    // Register read mux; the unused 0xC slot reads as zero
    always_comb begin
        rd_data = 32'd0;
        case (rd_off)
            MTIME:    rd_data = mtime_r;
            MTIMECMP: rd_data = mtimecmp_r;
            CTRL:     rd_data = {31'd0, enable_r};
            default:  rd_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/rv_sys_mem.sv
// Bus-side RAM and timer slave: captures one request, waits a fixed number
// of cycles, then acknowledges with read data or commits the write.
module rv_sys_mem
    import rv_sys_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] TIMER_BASE  = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ads,
    input  logic        rd_wr_n,
    input  logic        i_dn,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        ack,
    output logic        intr
);

    localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    state_e      state_r, state_s;
    logic [3:0]  wait_cnt_r;
    logic [31:0] addr_r, wr_data_r;
    logic [3:0]  be_r;
    logic        rd_wr_n_r, i_dn_r;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] req_addr_s;
    logic        req_rd_s;
    region_e     req_region_s, cmt_region_s;
    logic        commit_s, ram_we_s, tmr_we_s;
    logic [31:0] tmr_rd_s, rd_next_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; the counter is 1 in the last WAIT cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ads) begin
                    state_s = (WAIT_INIT == 4'd0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request capture and wait-state countdown
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
            addr_r     <= 32'd0;
            wr_data_r  <= 32'd0;
            be_r       <= 4'd0;
            rd_wr_n_r  <= 1'b1;
            i_dn_r     <= 1'b0;
        end else if ((state_r == ST_IDLE) && ads) begin
            wait_cnt_r <= WAIT_INIT;
            addr_r     <= addr;
            wr_data_r  <= wr_data;
            be_r       <= be;
            rd_wr_n_r  <= rd_wr_n;
            i_dn_r     <= i_dn;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // With zero wait states the response is built straight from the bus inputs
    assign req_addr_s   = (state_r == ST_IDLE) ? addr : addr_r;
    assign req_rd_s     = (state_r == ST_IDLE) ? rd_wr_n : rd_wr_n_r;
    assign req_region_s = decode_region(req_addr_s, RAM_BYTES, TIMER_BASE);

    // Writes commit in RESP; instruction-side writes are acknowledged no-ops
    assign cmt_region_s = decode_region(addr_r, RAM_BYTES, TIMER_BASE);
    assign commit_s     = !reset && (state_r == ST_RESP) && !rd_wr_n_r && !i_dn_r;
    assign ram_we_s     = commit_s && (cmt_region_s == REG_RAM);
    assign tmr_we_s     = commit_s && (cmt_region_s == REG_TIMER);

    // RAM byte-lane writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we_s && be_r[i]) begin
                mem[addr_r[AW+1:2]][8*i +: 8] <= wr_data_r[8*i +: 8];
            end
        end
    end

    rv_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .we      (tmr_we_s),
        .wr_off  (addr_r[3:0]),
        .be      (be_r),
        .wr_data (wr_data_r),
        .rd_off  (req_addr_s[3:0]),
        .rd_data (tmr_rd_s),
        .intr    (intr)
    );

    // FSM output logic: read data for the upcoming ack cycle, else zero
    always_comb begin
        rd_next_s = 32'd0;
        if ((state_s == ST_RESP) && req_rd_s) begin
            case (req_region_s)
                REG_RAM:   rd_next_s = mem[req_addr_s[AW+1:2]];
                REG_TIMER: rd_next_s = tmr_rd_s;
                default:   rd_next_s = 32'd0;
            endcase
        end else begin
            rd_next_s = 32'd0;
        end
    end

    // Registered bus outputs, high/valid exactly while the FSM is in RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            ack     <= 1'b0;
            rd_data <= 32'd0;
        end else begin
            ack     <= (state_s == ST_RESP);
            rd_data <= rd_next_s;
        end
    end

endmodule

// File: tb/tb_rv_sys_mem.sv
// Directed bench for rv_sys_mem: one instance with one wait state and one
// with zero wait states, sharing clock and reset.
module tb_rv_sys_mem;

    localparam int unsigned  WS0   = 1;
    localparam int unsigned  WS1   = 0;
    localparam logic [31:0]  TBASE = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic [1:0]  ads_v, rd_wr_n_v, i_dn_v, ack_v, intr_v;
    logic [31:0] addr_v [2];
    logic [3:0]  be_v [2];
    logic [31:0] wr_data_v [2];
    logic [31:0] rd_data_v [2];

    int          n_tests;
    int          n_fail;
    logic [31:0] tb_mtime;

    rv_sys_mem #(.MEM_WORDS(1024), .WAIT_STATES(WS0), .TIMER_BASE(TBASE)) dut0 (
        .clk(clk), .reset(reset), .ads(ads_v[0]), .rd_wr_n(rd_wr_n_v[0]), .i_dn(i_dn_v[0]),
        .addr(addr_v[0]), .be(be_v[0]), .wr_data(wr_data_v[0]),
        .rd_data(rd_data_v[0]), .ack(ack_v[0]), .intr(intr_v[0])
    );

    rv_sys_mem #(.MEM_WORDS(1024), .WAIT_STATES(WS1), .TIMER_BASE(TBASE)) dut1 (
        .clk(clk), .reset(reset), .ads(ads_v[1]), .rd_wr_n(rd_wr_n_v[1]), .i_dn(i_dn_v[1]),
        .addr(addr_v[1]), .be(be_v[1]), .wr_data(wr_data_v[1]),
        .rd_data(rd_data_v[1]), .ack(ack_v[1]), .intr(intr_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference time base: counts like mtime of dut0 from the same reset
    always @(posedge clk) begin
        if (reset) tb_mtime <= 32'd0;
        else       tb_mtime <= tb_mtime + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus transaction on instance u, checking ack timing and rd_data each cycle
    task automatic bus_xfer(input int u, input logic rd, input logic idn, input logic [31:0] a,
                            input logic [3:0] b, input logic [31:0] d,
                            input logic [31:0] exp_rd, input string tag);
        int lat;
        lat = (u == 0) ? int'(WS0) + 1 : int'(WS1) + 1;
        @(negedge clk);
        ads_v[u] = 1'b1; rd_wr_n_v[u] = rd; i_dn_v[u] = idn;
        addr_v[u] = a; be_v[u] = b; wr_data_v[u] = d;
        check_eq({tag, "_ack_at_ads"}, 32'(ack_v[u]), 32'd0);
        @(negedge clk);
        ads_v[u] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            if (k < lat) begin
                check_eq({tag, "_ack_early"}, 32'(ack_v[u]), 32'd0);
                check_eq({tag, "_rd_early"}, rd_data_v[u], 32'd0);
            end else begin
                check_eq({tag, "_ack"}, 32'(ack_v[u]), 32'd1);
                check_eq({tag, "_rd"}, rd_data_v[u], rd ? exp_rd : 32'd0);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        ads_v = 2'b00; rd_wr_n_v = 2'b11; i_dn_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = 32'd0; be_v[i] = 4'd0; wr_data_v[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_ack", 32'(ack_v[0]), 32'd0);
        check_eq("rst_rd", rd_data_v[0], 32'd0);
        check_eq("rst_intr", 32'(intr_v[0]), 32'd0);
        bus_xfer(0, 1'b1, 1'b0, TBASE + 32'h4, 4'hF, 32'd0, 32'hFFFF_FFFF, "rst_cmp");
        bus_xfer(0, 1'b1, 1'b0, TBASE + 32'h8, 4'hF, 32'd0, 32'h0, "rst_ctrl");

        // Basic write/read latency
        bus_xfer(0, 1'b0, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'd0, "wr10");
        bus_xfer(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'd0, 32'hDEAD_BEEF, "rd10");

        // Byte lanes
        bus_xfer(0, 1'b0, 1'b0, 32'h20, 4'hF, 32'h1122_3344, 32'd0, "wr20");
        bus_xfer(0, 1'b0, 1'b0, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'd0, "wr20_be");
        bus_xfer(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'd0, 32'h11BB_33DD, "rd20_be");
        bus_xfer(0, 1'b0, 1'b0, 32'h20, 4'h0, 32'hFFFF_FFFF, 32'd0, "wr20_be0");
        bus_xfer(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0, 32'h11BB_33DD, "rd20_be0");

        // Unmapped and illegal accesses
        bus_xfer(0, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'd0, 32'd0, "rd_unmap");
        bus_xfer(0, 1'b0, 1'b0, 32'h0, 4'hF, 32'h5A5A_A5A5, 32'd0, "wr0");
        bus_xfer(0, 1'b0, 1'b1, 32'h0, 4'hF, 32'hFFFF_FFFF, 32'd0, "wr0_idn");
        bus_xfer(0, 1'b1, 1'b0, 32'h0, 4'hF, 32'd0, 32'h5A5A_A5A5, "rd0");
        bus_xfer(0, 1'b1, 1'b0, TBASE + 32'hC, 4'hF, 32'd0, 32'd0, "rd_tmr_c");

        // Reset during WAIT of a write aborts it
        bus_xfer(0, 1'b0, 1'b0, 32'h30, 4'hF, 32'h1234_5678, 32'd0, "wr30");
        @(negedge clk);
        ads_v[0] = 1'b1; rd_wr_n_v[0] = 1'b0; i_dn_v[0] = 1'b0;
        addr_v[0] = 32'h30; be_v[0] = 4'hF; wr_data_v[0] = 32'hFFFF_0000;
        @(negedge clk);
        ads_v[0] = 1'b0;
        reset = 1'b1;
        check_eq("abort_ack_wait", 32'(ack_v[0]), 32'd0);
        @(negedge clk);
        check_eq("abort_ack_rst", 32'(ack_v[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_ack_after", 32'(ack_v[0]), 32'd0);
        bus_xfer(0, 1'b1, 1'b0, 32'h30, 4'hF, 32'd0, 32'h1234_5678, "rd30");

        // Timer interrupt (mtime restarted by the reset above)
        bus_xfer(0, 1'b0, 1'b0, TBASE + 32'h4, 4'hF, 32'd50, 32'd0, "wr_cmp");
        bus_xfer(0, 1'b0, 1'b0, TBASE + 32'h8, 4'hF, 32'd1, 32'd0, "wr_ctrl");
        bus_xfer(0, 1'b1, 1'b0, TBASE + 32'h4, 4'hF, 32'd0, 32'd50, "rd_cmp");
        bus_xfer(0, 1'b1, 1'b0, TBASE + 32'h8, 4'hF, 32'd0, 32'd1, "rd_ctrl");
        check_eq("intr_before", 32'(intr_v[0]), 32'd0);
        for (int i = 0; (i < 200) && (tb_mtime != 32'd50); i++) @(negedge clk);
        check_eq("timer_wait", tb_mtime, 32'd50);
        check_eq("intr_at50", 32'(intr_v[0]), 32'd0);
        @(negedge clk);
        check_eq("intr_at51", 32'(intr_v[0]), 32'd1);
        bus_xfer(0, 1'b0, 1'b0, TBASE + 32'h4, 4'hF, 32'hFFFF_FFFF, 32'd0, "wr_cmp_max");
        @(negedge clk);
        check_eq("intr_ack_p1", 32'(intr_v[0]), 32'd1);
        @(negedge clk);
        check_eq("intr_ack_p2", 32'(intr_v[0]), 32'd0);

        // Zero wait states, back-to-back
        bus_xfer(1, 1'b0, 1'b0, 32'h40, 4'hF, 32'hAAAA_5555, 32'd0, "z_wr40");
        bus_xfer(1, 1'b0, 1'b0, 32'h44, 4'hF, 32'h0F0F_F0F0, 32'd0, "z_wr44");
        bus_xfer(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 32'hAAAA_5555, "z_rd40");
        bus_xfer(1, 1'b1, 1'b1, 32'h44, 4'hF, 32'd0, 32'h0F0F_F0F0, "z_rd44");
        bus_xfer(1, 1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 32'hAAAA_5555, "z_rd40b");
        @(negedge clk);
        check_eq("z_ack_idle", 32'(ack_v[1]), 32'd0);
        check_eq("z_rd_idle", rd_data_v[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_sys_mem.md
# rv_sys_mem

Bus-side system memory and timer slave for the RV CPU core. Sits directly downstream of the CPU's external bus and consumes its transactions (`ads`, `rd_wr_n`, `i_dn`, `addr`, `be`, `wr_data`). It answers each transaction with `ack` and `rd_data` after a programmable number of wait states. It also hosts a memory-mapped timer that drives the CPU's `intr` input.

## Interface
- `MEM_WORDS`, default 1024: RAM depth in 32-bit words; RAM occupies bytes 0 .. `MEM_WORDS`*4-1.
- `WAIT_STATES`, default 1: extra cycles inserted between request capture and `ack`; legal range 0..15.
- `TIMER_BASE`, default 32'h8000_0000: base byte address of the timer register block (16 bytes).
- `clk` input 1: system clock; the block has one clock domain.
- `reset` input 1: reset is synchronous and active-high.
- `ads` input 1: address/request valid, one-cycle strobe from the CPU.
- `rd_wr_n` input 1: 1 = read, 0 = write.
- `i_dn` input 1: 1 = instruction fetch, 0 = data access.
- `addr` input 32: byte address; bits [1:0] ignored.
- `be` input 4: byte enables for writes; `be[i]` selects `wr_data[8i+7:8i]`.
- `wr_data` input 32: write data.
- `rd_data` output 32: read data; valid only in the `ack` cycle, 0 otherwise.
- `ack` output 1: one-cycle completion strobe for the captured transaction.
- `intr` output 1: timer interrupt request, level.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, `ads`=1:
  - Capture `addr`, `be`, `wr_data`, `rd_wr_n`, `i_dn`.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or go directly to RESP if `WAIT_STATES`=0.
- WAIT: decrement the counter each cycle; go to RESP in the cycle the counter reaches 0.
- RESP:
  - Drive `ack`=1.
  - On a read, drive the decoded read data on `rd_data`.
  - On a write, commit the write in this cycle.
  - Return to IDLE.
- `ads` outside IDLE is ignored. The CPU issues the next request only after `ack`. Back-to-back is allowed: `ads` in the cycle after `ack` is captured.
- Address decode (captured `addr`):
  - RAM: `addr` < `MEM_WORDS`*4.
  - Timer: `TIMER_BASE` + {0x0, 0x4, 0x8}.
  - Everything else is unmapped.
- RAM reads return the full word, with `be` ignored. RAM writes update only enabled byte lanes; a write with `be`=0 leaves the word unchanged.
- Timer registers:
  - 0x0 `mtime`: free-running +1 every cycle, wraps at 2^32, read-only; writes dropped.
  - 0x4 `mtimecmp`: read/write; `be` honoured.
  - 0x8 `ctrl`: bit0 = enable, other bits read 0.
  - 0xC reads 0.
- `intr` is registered: `intr` <= `ctrl[0]` && (`mtime` >= `mtimecmp`). Clearing is by software writing `mtimecmp` higher or clearing enable.
- Unmapped reads return 0; unmapped writes are dropped. Both still receive `ack`.
- Any transaction with `i_dn`=1 and `rd_wr_n`=0 is treated as a no-op write: acked, no state change.

## Timing
- Latency from the `ads` cycle to the `ack` cycle is `WAIT_STATES`+1 clocks.
- Throughput is one transaction per `WAIT_STATES`+2 clocks when requests are issued back-to-back.
- A write is visible to a read whose `ads` is sampled in or after the cycle following that write's `ack`.
- After a `mtimecmp`/`ctrl` write commits in RESP, `intr` reflects the new value two cycles later.
- Reset values:
  - `rd_data`=0, `ack`=0, `intr`=0, FSM = IDLE, wait counter 0.
  - `mtime`=0, `mtimecmp`=32'hFFFF_FFFF, `ctrl`=0.
  - RAM contents are not reset.
- Reset during WAIT or RESP aborts the transaction: no write is committed and no `ack` follows.
- `mtime` wrap: 32'hFFFF_FFFF -> 0. The comparison is unsigned, so `intr` deasserts after wrap unless `mtimecmp`=0.

## Structure
- Shared package `rv_sys_pkg`:
  - FSM state enum.
  - Timer offset constants (`MTIME`=0x0, `MTIMECMP`=0x4, `CTRL`=0x8).
  - Region-decode enum (RAM/TIMER/NONE) and a decode function.
- Sub-module `rv_timer`: owns `mtime`, `mtimecmp`, `ctrl` and `intr`. It has a register write port (offset, `be`, data, we) and a read port.
- RAM is an inferred array in `rv_sys_mem`.

## Test plan
- Read latency: `WAIT_STATES`=1. Write 32'hDEAD_BEEF to 0x10 with `be`=4'hF, then read 0x10. Expect `ack` exactly 2 cycles after each `ads`, `rd_data`=32'hDEAD_BEEF in the read's `ack` cycle, and 0 in all other cycles.
- Byte lanes: with 0x20=32'h1122_3344, write 32'hAABB_CCDD with `be`=4'b0101. Read back 32'h11BB_33DD. A following write with `be`=0 leaves the value unchanged.
- Unmapped and illegal accesses:
  - Read `MEM_WORDS`*4 -> `ack`, `rd_data`=0.
  - Write with `i_dn`=1 to 0x0 -> `ack`, RAM[0] unchanged.
- Timer interrupt: write `mtimecmp`=50 and `ctrl`=1. `intr` rises when `mtime` reaches 50 (+1 register cycle). Writing `mtimecmp`=32'hFFFF_FFFF drops `intr` two cycles after that write's `ack`.
- Reset mid-transaction and zero wait: assert `reset` during WAIT of a write to 0x30. Expect no `ack` and RAM[0x30] unchanged. Then, with `WAIT_STATES`=0, back-to-back reads each `ack` in the cycle after `ads`.
